ram_loader: RTL and testbench

//  Host-side master for RAM port A: consumes a byte command stream (valid/ready), packs bytes into
//  32-bit words and writes them to RAM, or reads words back and streams them out as bytes.

---
 rtl/ram_loader_pkg.sv | 26 ++
 rtl/ram_loader_if.sv | 31 +++
 rtl/ram_loader_word_serializer.sv | 39 +++
 rtl/ram_loader.sv | 178 +++++++++++++++++
 tb/tb_ram_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_loader_pkg.sv
// Shared opcodes, response byte and FSM state type for the host RAM loader.
package ram_loader_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
   localparam logic [7:0] OP_GO    = 8'h47;  // 'G'
   localparam logic [7:0] OP_HALT  = 8'h48;  // 'H'
   localparam logic [7:0] ACK_BYTE = 8'h06;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WDATA,
      S_WSTORE,
      S_RREQ,
      S_RWAIT,
      S_RSEND,
      S_ACK
   } loader_state_t;

   // A count byte of zero stands for a full 256-word burst.
   function automatic logic [8:0] word_count(input logic [7:0] cnt);
      return (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
   endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Host byte streams, RAM port A and core control grouped as one bundle.
// master = the loader, slave = host link / RAM / core side.
interface ram_loader_if #(
   parameter int ADDR_WIDTH = 8
) ();
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  a_wr_en;
   logic [3:0]            a_wr_strobe;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [31:0]           a_data_in;
   logic [31:0]           a_data_out;
   logic                  core_hold;
   logic                  cmd_err;

   modport master (
      input  rx_data, rx_valid, tx_ready, a_data_out,
      output rx_ready, tx_data, tx_valid, a_wr_en, a_wr_strobe, a_addr,
             a_data_in, core_hold, cmd_err
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, a_data_out,
      input  rx_ready, tx_data, tx_valid, a_wr_en, a_wr_strobe, a_addr,
             a_data_in, core_hold, cmd_err
   );
endinterface

// File: rtl/ram_loader_word_serializer.sv
// Loads a 32-bit word and emits it as 4 bytes, LSB first, over valid/ready.
// done pulses in the cycle the last byte is accepted.
module word_serializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] word,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);
   logic [31:0] shift;
   logic [1:0]  idx;
   logic        busy;

   // Shift out one byte per accepted transfer; bytes already sent are zero-filled.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift <= 32'h0;
         idx   <= 2'd0;
         busy  <= 1'b0;
      end else if (load) begin
         shift <= word;
         idx   <= 2'd0;
         busy  <= 1'b1;
      end else if (busy && tx_ready) begin
         shift <= {8'h00, shift[31:8]};
         idx   <= idx + 2'd1;
         if (idx == 2'd3)
            busy <= 1'b0;
      end
   end

   assign tx_data  = shift[7:0];
   assign tx_valid = busy;
   assign done     = busy & tx_ready & (idx == 2'd3);

endmodule

// File: rtl/ram_loader.sv
// Host-side master for RAM port A: decodes the byte command stream, packs
// write data into words, streams read words back as bytes and controls the
// core hold line. ADDR_WIDTH must not exceed 16.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   ram_loader_if.master bus
);
   loader_state_t         state, state_nx;
   logic [1:0]            byte_idx;
   logic                  is_write;
   logic [7:0]            addr_lo;
   logic [8:0]            words_left;
   logic [31:0]           wdata;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  core_hold_r;
   logic                  cmd_err_r;
   logic                  rx_accept;
   logic                  rx_fire;
   logic                  wr_en;
   logic                  ser_load;
   logic                  tx_valid_c;
   logic [7:0]            tx_data_c;
   logic [7:0]            ser_data;
   logic                  ser_valid;
   logic                  ser_done;

   // Only the byte-collecting states take input; reset holds rx_ready low.
   assign rx_accept = ~reset & ((state == S_IDLE) | (state == S_HDR) | (state == S_WDATA));
   assign rx_fire   = bus.rx_valid & rx_accept;

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next state and per-state outputs; reset masks every strobe so an
   // aborted command can never reach the RAM.
   always_comb begin
      state_nx   = state;
      wr_en      = 1'b0;
      ser_load   = 1'b0;
      tx_valid_c = 1'b0;
      tx_data_c  = 8'h00;
      case (state)
         S_IDLE: begin
            if (rx_fire) begin
               case (bus.rx_data)
                  OP_WRITE, OP_READ: state_nx = S_HDR;
                  OP_GO, OP_HALT:    state_nx = S_ACK;
                  default:           state_nx = S_IDLE;
               endcase
            end
         end
         S_HDR:    if (rx_fire && byte_idx == 2'd2) state_nx = is_write ? S_WDATA : S_RREQ;
         S_WDATA:  if (rx_fire && byte_idx == 2'd3) state_nx = S_WSTORE;
         S_WSTORE: begin
            wr_en    = 1'b1;
            state_nx = (words_left == 9'd1) ? S_ACK : S_WDATA;
         end
         S_RREQ:   state_nx = S_RWAIT;
         S_RWAIT: begin
            // RAM data for the address presented in RREQ is valid now.
            ser_load = 1'b1;
            state_nx = S_RSEND;
         end
         S_RSEND: begin
            tx_valid_c = ser_valid;
            tx_data_c  = ser_data;
            if (ser_done)
               state_nx = (words_left == 9'd1) ? S_IDLE : S_RREQ;
         end
         S_ACK: begin
            tx_valid_c = 1'b1;
            tx_data_c  = ACK_BYTE;
            if (bus.tx_ready)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (reset) begin
         wr_en      = 1'b0;
         ser_load   = 1'b0;
         tx_valid_c = 1'b0;
         tx_data_c  = 8'h00;
      end
   end

   // Header capture, word packing, address/count tracking and control flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx    <= 2'd0;
         is_write    <= 1'b0;
         addr_lo     <= 8'h00;
         words_left  <= 9'd0;
         wdata       <= 32'h0;
         addr        <= '0;
         core_hold_r <= 1'b1;
         cmd_err_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_fire) begin
                  byte_idx <= 2'd0;
                  case (bus.rx_data)
                     OP_WRITE: is_write    <= 1'b1;
                     OP_READ:  is_write    <= 1'b0;
                     OP_GO:    core_hold_r <= 1'b0;
                     OP_HALT:  core_hold_r <= 1'b1;
                     default:  cmd_err_r   <= 1'b1;
                  endcase
               end
            end
            S_HDR: begin
               if (rx_fire) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: addr_lo <= bus.rx_data;
                     // Upper address bits beyond ADDR_WIDTH are dropped here.
                     2'd1: addr    <= ADDR_WIDTH'({bus.rx_data, addr_lo});
                     default: begin
                        words_left <= word_count(bus.rx_data);
                        byte_idx   <= 2'd0;
                     end
                  endcase
               end
            end
            S_WDATA: begin
               // Little-endian: the first byte received ends up in bits [7:0].
               if (rx_fire) begin
                  wdata    <= {bus.rx_data, wdata[31:8]};
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_WSTORE: begin
               addr       <= addr + ADDR_WIDTH'(1);
               words_left <= words_left - 9'd1;
            end
            S_RSEND: begin
               if (ser_done) begin
                  addr       <= addr + ADDR_WIDTH'(1);
                  words_left <= words_left - 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

   word_serializer u_ser (
      .clk      (clk),
      .reset    (reset),
      .load     (ser_load),
      .word     (bus.a_data_out),
      .tx_data  (ser_data),
      .tx_valid (ser_valid),
      .tx_ready (bus.tx_ready),
      .done     (ser_done)
   );

   assign bus.rx_ready    = rx_accept;
   assign bus.tx_valid    = tx_valid_c;
   assign bus.tx_data     = tx_data_c;
   assign bus.a_wr_en     = wr_en;
   assign bus.a_wr_strobe = wr_en ? 4'hF : 4'h0;
   assign bus.a_addr      = addr;
   assign bus.a_data_in   = wdata;
   assign bus.core_hold   = core_hold_r;
   assign bus.cmd_err     = cmd_err_r;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: behavioural RAM, word-level memory
// model and byte-stream scoreboards.
module tb_ram_loader;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ram_loader_if #(.ADDR_WIDTH(AW)) bus ();
   ram_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   wr_t         wr_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] ram     [256];
   logic [31:0] exp_mem [256];
   logic [31:0] wbuf    [256];

   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   stall_viol = 0;
   int   wr_lat_bad = 0;
   int   rd_lat_bad = 0;
   int   tx_mode = 0;
   bit   gap_en = 1'b0;
   bit   prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // Host tx_ready: 0 = always ready, 1 = toggling, 2 = random
   always @(negedge clk) begin
      case (tx_mode)
         1:       bus.tx_ready = (bus.tx_ready === 1'b1) ? 1'b0 : 1'b1;
         2:       bus.tx_ready = 1'($urandom_range(0, 1));
         default: bus.tx_ready = 1'b1;
      endcase
   end

   // Behavioural RAM plus write / tx monitors
   always @(posedge clk) begin
      bus.a_data_out <= ram[bus.a_addr];
      if (bus.a_wr_en === 1'b1) begin
         wr_q.push_back('{addr: bus.a_addr, data: bus.a_data_in, strb: bus.a_wr_strobe});
         for (int b = 0; b < 4; b++)
            if (bus.a_wr_strobe[b]) ram[bus.a_addr][8*b +: 8] = bus.a_data_in[8*b +: 8];
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1)
         tx_q.push_back(bus.tx_data);
      if (!reset && prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data))
         stall_viol++;
      prev_stall = !reset && bus.tx_valid === 1'b1 && bus.tx_ready !== 1'b1;
      prev_data  = bus.tx_data;
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired pass=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (bus.rx_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         total_cnt++;
         $display("FAIL rx_handshake timeout byte=%h", b);
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int need, input int budget);
      int k = 0;
      while (tx_q.size() < need && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (tx_q.size() < need) begin
         total_cnt++;
         $display("FAIL tx_wait got=%0d bytes need=%0d", tx_q.size(), need);
      end
   endtask

   // 'W' command from wbuf; updates the reference memory.
   task automatic do_write(input logic [15:0] addr, input logic [7:0] cnt);
      int n = (cnt == 0) ? 256 : int'(cnt);
      wr_q.delete();
      tx_q.delete();
      send_byte(8'h57);
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(cnt);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) send_byte(wbuf[i][8*b +: 8]);
         if (bus.a_wr_en !== 1'b1) wr_lat_bad++;
         exp_mem[(int'(addr) + i) % (1 << AW)] = wbuf[i];
      end
      wait_tx(1, 200);
   endtask

   // 'R' command; also records whether the first byte shows up exactly 2 cycles on.
   task automatic do_read(input logic [15:0] addr, input logic [7:0] cnt);
      int n = (cnt == 0) ? 256 : int'(cnt);
      logic v0, v1, v2;
      wr_q.delete();
      tx_q.delete();
      send_byte(8'h52);
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(cnt);
      @(negedge clk); v0 = bus.tx_valid;
      @(negedge clk); v1 = bus.tx_valid;
      @(negedge clk); v2 = bus.tx_valid;
      if (!(v0 === 1'b0 && v1 === 1'b0 && v2 === 1'b1)) rd_lat_bad++;
      wait_tx(4 * n, 4 * n * 10 + 100);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (bus.rx_ready !== 1'b0) $display("FAIL reset_rx_ready got=%b exp=0", bus.rx_ready);
      else pass_cnt++;
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({bus.core_hold, bus.a_wr_en, bus.tx_valid, bus.cmd_err} !== 4'b1000)
         $display("FAIL reset_ctrl got hold/wr/txv/err=%b%b%b%b exp=1000",
                  bus.core_hold, bus.a_wr_en, bus.tx_valid, bus.cmd_err);
      else pass_cnt++;
      total_cnt++;
      if ({bus.a_addr, bus.a_data_in, bus.a_wr_strobe, bus.tx_data} !== 52'h0)
         $display("FAIL reset_data got addr=%h din=%h strb=%h tx=%h exp=0",
                  bus.a_addr, bus.a_data_in, bus.a_wr_strobe, bus.tx_data);
      else pass_cnt++;
      total_cnt++;
      if (bus.rx_ready !== 1'b1) $display("FAIL reset_release_rx_ready got=%b exp=1", bus.rx_ready);
      else pass_cnt++;
   endtask

   task automatic test_write();
      wbuf[0] = 32'h12345678;
      wbuf[1] = 32'hDEADBEEF;
      wr_lat_bad = 0;
      do_write(16'h0004, 8'd2);
      total_cnt++;
      if (wr_q.size() !== 2) $display("FAIL write_count got=%0d exp=2", wr_q.size());
      else pass_cnt++;
      for (int i = 0; i < 2 && i < wr_q.size(); i++) begin
         total_cnt++;
         if ({wr_q[i].addr, wr_q[i].data, wr_q[i].strb} !== {8'(4 + i), wbuf[i], 4'hF})
            $display("FAIL write_word%0d got addr=%h data=%h strb=%h exp addr=%h data=%h strb=f",
                     i, wr_q[i].addr, wr_q[i].data, wr_q[i].strb, 8'(4 + i), wbuf[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (wr_lat_bad !== 0) $display("FAIL write_latency got=%0d late words exp=0", wr_lat_bad);
      else pass_cnt++;
      total_cnt++;
      if (tx_q.size() !== 1 || tx_q[0] !== 8'h06)
         $display("FAIL write_ack got size=%0d first=%h exp 1 byte 06", tx_q.size(),
                  (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      else pass_cnt++;
   endtask

   task automatic test_read_backpressure();
      int bad = 0;
      tx_mode = 1;
      stall_viol = 0;
      rd_lat_bad = 0;
      do_read(16'h0004, 8'd2);
      total_cnt++;
      if (tx_q.size() !== 8) $display("FAIL read_count got=%0d exp=8", tx_q.size());
      else pass_cnt++;
      for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
         logic [31:0] w = exp_mem[(4 + i / 4) % 256];
         total_cnt++;
         if (tx_q[i] !== w[8*(i%4) +: 8])
            $display("FAIL read_byte%0d got=%h exp=%h", i, tx_q[i], w[8*(i%4) +: 8]);
         else pass_cnt++;
      end
      total_cnt++;
      if (stall_viol !== 0) $display("FAIL read_stall_stable got=%0d violations exp=0", stall_viol);
      else pass_cnt++;
      total_cnt++;
      if (rd_lat_bad !== 0) $display("FAIL read_latency got=%0d exp=0", rd_lat_bad);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({bus.tx_valid, bus.rx_ready} !== 2'b01)
         $display("FAIL read_idle got txv/rxr=%b%b exp=01", bus.tx_valid, bus.rx_ready);
      else pass_cnt++;
      tx_mode = 0;
   endtask

   task automatic test_wrap();
      wbuf[0] = $urandom;
      wbuf[1] = $urandom;
      do_write(16'h00FF, 8'd2);
      total_cnt++;
      if (wr_q.size() !== 2) $display("FAIL wrap_count got=%0d exp=2", wr_q.size());
      else pass_cnt++;
      if (wr_q.size() == 2) begin
         total_cnt++;
         if ({wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data} !==
             {8'hFF, wbuf[0], 8'h00, wbuf[1]})
            $display("FAIL wrap_addr got %h:%h %h:%h exp ff:%h 00:%h", wr_q[0].addr,
                     wr_q[0].data, wr_q[1].addr, wr_q[1].data, wbuf[0], wbuf[1]);
         else pass_cnt++;
      end
   endtask

   task automatic test_control();
      tx_q.delete();
      send_byte(8'h47);
      total_cnt++;
      if (bus.core_hold !== 1'b0) $display("FAIL go_hold got=%b exp=0", bus.core_hold);
      else pass_cnt++;
      wait_tx(1, 50);
      total_cnt++;
      if (tx_q.size() !== 1 || tx_q[0] !== 8'h06) $display("FAIL go_ack got size=%0d exp 1 byte 06", tx_q.size());
      else pass_cnt++;
      tx_q.delete();
      send_byte(8'h99);
      repeat (10) @(negedge clk);
      total_cnt++;
      if ({bus.cmd_err, bus.rx_ready, bus.core_hold} !== 3'b110 || tx_q.size() !== 0)
         $display("FAIL bad_opcode got err/rxr/hold=%b%b%b tx=%0d exp=110 tx=0",
                  bus.cmd_err, bus.rx_ready, bus.core_hold, tx_q.size());
      else pass_cnt++;
      send_byte(8'h48);
      total_cnt++;
      if (bus.core_hold !== 1'b1) $display("FAIL halt_hold got=%b exp=1", bus.core_hold);
      else pass_cnt++;
      wait_tx(1, 50);
      total_cnt++;
      if (tx_q.size() !== 1 || tx_q[0] !== 8'h06 || bus.cmd_err !== 1'b1)
         $display("FAIL halt_ack got size=%0d err=%b exp 1 byte 06 err=1", tx_q.size(), bus.cmd_err);
      else pass_cnt++;
   endtask

   task automatic test_cnt_zero();
      int bad = 0;
      for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
      wr_lat_bad = 0;
      do_write(16'h5A80, 8'd0);
      total_cnt++;
      if (wr_q.size() !== 256) $display("FAIL cnt0_write_count got=%0d exp=256", wr_q.size());
      else pass_cnt++;
      for (int i = 0; i < wr_q.size() && i < 256; i++)
         if (wr_q[i].addr !== 8'((8'h80 + i) % 256) || wr_q[i].data !== wbuf[i]) bad++;
      total_cnt++;
      if (bad !== 0 || wr_lat_bad !== 0)
         $display("FAIL cnt0_write_words got=%0d bad latency=%0d exp=0", bad, wr_lat_bad);
      else pass_cnt++;
      bad = 0;
      do_read(16'h0080, 8'd0);
      for (int i = 0; i < tx_q.size() && i < 1024; i++)
         if (tx_q[i] !== exp_mem[(8'h80 + i / 4) % 256][8*(i%4) +: 8]) bad++;
      total_cnt++;
      if (tx_q.size() !== 1024 || bad !== 0)
         $display("FAIL cnt0_read got size=%0d bad=%0d exp size=1024 bad=0", tx_q.size(), bad);
      else pass_cnt++;
   endtask

   task automatic test_random();
      gap_en = 1'b1;
      tx_mode = 2;
      for (int it = 0; it < 6; it++) begin
         logic [15:0] a = 16'($urandom);
         logic [7:0]  c = 8'($urandom_range(1, 6));
         int bad = 0;
         for (int i = 0; i < int'(c); i++) wbuf[i] = $urandom;
         do_write(a, c);
         for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i].addr !== 8'((int'(a) + i) % 256) || wr_q[i].data !== wbuf[i] ||
                wr_q[i].strb !== 4'hF) bad++;
         total_cnt++;
         if (bad !== 0 || wr_q.size() !== int'(c) || tx_q.size() !== 1 || tx_q[0] !== 8'h06)
            $display("FAIL rand_write%0d got words=%0d bad=%0d exp words=%0d bad=0",
                     it, wr_q.size(), bad, c);
         else pass_cnt++;
         // read a window overlapping the fresh write and its neighbours
         a = a - 16'd1;
         c = c + 8'd2;
         bad = 0;
         stall_viol = 0;
         do_read(a, c);
         for (int i = 0; i < tx_q.size(); i++)
            if (tx_q[i] !== exp_mem[(int'(a) + i / 4) % 256][8*(i%4) +: 8]) bad++;
         total_cnt++;
         if (bad !== 0 || tx_q.size() !== 4 * int'(c) || stall_viol !== 0)
            $display("FAIL rand_read%0d got bytes=%0d bad=%0d stall=%0d exp bytes=%0d",
                     it, tx_q.size(), bad, stall_viol, 4 * c);
         else pass_cnt++;
      end
      gap_en = 1'b0;
      tx_mode = 0;
      total_cnt++;
      if (rd_lat_bad !== 0) $display("FAIL rand_read_latency got=%0d exp=0", rd_lat_bad);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      tx_q.delete();
      send_byte(8'h47);
      wait_tx(1, 50);
      wr_q.delete();
      send_byte(8'h57);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({bus.core_hold, bus.cmd_err, bus.tx_valid, bus.a_wr_en, bus.rx_ready} !== 5'b10001)
         $display("FAIL abort_ctrl got hold/err/txv/wr/rxr=%b%b%b%b%b exp=10001",
                  bus.core_hold, bus.cmd_err, bus.tx_valid, bus.a_wr_en, bus.rx_ready);
      else pass_cnt++;
      total_cnt++;
      if ({bus.a_addr, bus.a_data_in, bus.a_wr_strobe, bus.tx_data} !== 52'h0)
         $display("FAIL abort_data got addr=%h din=%h strb=%h tx=%h exp=0",
                  bus.a_addr, bus.a_data_in, bus.a_wr_strobe, bus.tx_data);
      else pass_cnt++;
      repeat (6) @(negedge clk);
      total_cnt++;
      if (wr_q.size() !== 0 || bus.tx_valid !== 1'b0)
         $display("FAIL abort_no_write got writes=%0d txv=%b exp 0 0", wr_q.size(), bus.tx_valid);
      else pass_cnt++;
      wbuf[0] = 32'hCAFEF00D;
      do_write(16'h0020, 8'd1);
      total_cnt++;
      if (wr_q.size() !== 1 || wr_q[0].addr !== 8'h20 || wr_q[0].data !== 32'hCAFEF00D)
         $display("FAIL abort_recover got writes=%0d exp one write 20:cafef00d", wr_q.size());
      else pass_cnt++;
   endtask

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = $urandom;
         exp_mem[i] = ram[i];
      end
      test_reset();
      test_write();
      test_read_backpressure();
      test_wrap();
      test_control();
      test_cnt_zero();
      test_random();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
